// File: rtl/load_ext_pkg.sv
// Shared definitions for the load-data extract/extend stage:
// access-size encodings and the output-buffer occupancy states.
package load_ext_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Number of results held in the main + skid registers.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/extend_lane.sv
// Combinational extract/extend/alignment check for one load request.
// Data is big-endian: index 0 is the MSB and byte k lives in [8k:8k+7].
module extend_lane
  import load_ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [0:DATA_W-1] data,
  input  logic [OFF_W-1:0]  off,
  input  logic [1:0]        size,
  input  logic              sign,
  output logic [0:DATA_W-1] result,
  output logic              err
);

  localparam int IDX_W = $clog2(DATA_W);

  logic [IDX_W-1:0] byte_idx;
  logic [IDX_W-1:0] half_idx;
  logic [0:7]       byte_f;
  logic [0:15]      half_f;

  // Select the addressed field and place it at the LSB end, filling the
  // upper bits with the field's top bit (signed) or zeros. Errors yield 0.
  always_comb begin
    byte_idx    = {off, 3'b000};
    // The halfword select always uses an even byte so it never runs off
    // the end of the word; odd offsets are flagged as errors below.
    half_idx    = byte_idx;
    half_idx[3] = 1'b0;
    byte_f      = data[byte_idx +: 8];
    half_f      = data[half_idx +: 16];
    result      = '0;
    err         = 1'b0;
    case (size)
      SZ_BYTE: result = {{(DATA_W-8){sign & byte_f[0]}}, byte_f};
      SZ_HALF: begin
        if (off[0]) err = 1'b1;
        else        result = {{(DATA_W-16){sign & half_f[0]}}, half_f};
      end
      SZ_WORD: begin
        if (off != '0) err = 1'b1;
        else           result = data;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_extend_stage.sv
// Registered load extractor/extender with a valid/ready handshake on both
// sides and a main + skid output buffer.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// Payload is sampled only on an input transfer; out_data/out_err hold
// steady while out_valid && !out_ready. in_ready is a flop (occupancy < 2)
// so out_ready never reaches it combinationally.
module load_extend_stage
  import load_ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:DATA_W-1] in_data,
  input  logic [OFF_W-1:0]  in_off,
  input  logic [1:0]        in_size,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:DATA_W-1] out_data,
  output logic              out_err,
  output logic [1:0]        dbg_state
);

  occ_state_t        state;
  logic [0:DATA_W-1] lane_data;
  logic              lane_err;
  logic [0:DATA_W-1] skid_data;
  logic              skid_err;
  logic              in_xfer;
  logic              out_xfer;

  extend_lane #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_lane (
    .data   (in_data),
    .off    (in_off),
    .size   (in_size),
    .sign   (in_sign),
    .result (lane_data),
    .err    (lane_err)
  );

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign dbg_state = state;

  // Occupancy FSM: main register feeds the output, skid catches the one
  // extra result accepted while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            out_data  <= lane_data;
            out_err   <= lane_err;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            skid_data <= lane_data;
            skid_err  <= lane_err;
            in_ready  <= 1'b0;
            state     <= TWO;
          end else if (in_xfer && out_xfer) begin
            out_data <= lane_data;
            out_err  <= lane_err;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            out_data <= skid_data;
            out_err  <= skid_err;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_extend_stage.sv
// Directed bench for load_extend_stage at DATA_W=32 and DATA_W=64 with a
// reference model feeding per-instance expected queues.
module tb_load_extend_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  // 32-bit instance signals
  logic        iv32 = 1'b0, ir32, isg32 = 1'b0, ov32, or32 = 1'b0, oe32;
  logic [0:31] id32 = '0, od32;
  logic [1:0]  io32 = '0, isz32 = '0, dbg32;
  // 64-bit instance signals
  logic        iv64 = 1'b0, ir64, isg64 = 1'b0, ov64, or64 = 1'b0, oe64;
  logic [0:63] id64 = '0, od64;
  logic [2:0]  io64 = '0;
  logic [1:0]  isz64 = '0, dbg64;

  logic [32:0] exp_q32[$];
  logic [64:0] exp_q64[$];
  int n_cmp = 0, n_bad = 0;
  int acc_cnt32 = 0, pop_cnt32 = 0;

  load_extend_stage #(.DATA_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .in_data(id32),
    .in_off(io32), .in_size(isz32), .in_sign(isg32), .out_valid(ov32),
    .out_ready(or32), .out_data(od32), .out_err(oe32), .dbg_state(dbg32));

  load_extend_stage #(.DATA_W(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .in_data(id64),
    .in_off(io64), .in_size(isz64), .in_sign(isg64), .out_valid(ov64),
    .out_ready(or64), .out_data(od64), .out_err(oe64), .dbg_state(dbg64));

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: shift the addressed field down to the LSB end and extend.
  function automatic logic [64:0] model(input int w, input logic [63:0] d, input int off,
                                        input logic [1:0] sz, input logic s);
    int n;
    logic [63:0] f, m;
    if (sz == 2'b11) return {1'b1, 64'd0};
    n = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : w;
    if ((sz == 2'b01 && off % 2 != 0) || (sz == 2'b10 && off != 0)) return {1'b1, 64'd0};
    if (n == 64) return {1'b0, d};
    f = d >> (w - 8*off - n);
    m = (64'd1 << n) - 64'd1;
    f = f & m;
    if (s && f[n-1]) f = f | ~m;
    if (w == 32) f = f & 64'h0000_0000_FFFF_FFFF;
    return {1'b0, f};
  endfunction

  // scoreboard: push on input transfer, pop/compare on output transfer
  always @(negedge clk) begin
    logic [64:0] m;
    logic [32:0] e32;
    logic [64:0] e64;
    if (!rst_n) begin
      exp_q32.delete();
      exp_q64.delete();
    end else begin
      if (iv32 && ir32) begin
        m = model(32, {32'd0, id32}, int'(io32), isz32, isg32);
        exp_q32.push_back({m[64], m[31:0]});
        acc_cnt32++;
      end
      if (ov32 && or32) begin
        pop_cnt32++;
        check("out32_expected_avail", 65'(exp_q32.size() != 0), 65'd1);
        if (exp_q32.size() != 0) begin
          e32 = exp_q32.pop_front();
          check("out32_result", 65'({oe32, od32}), 65'(e32));
        end
      end
      if (iv64 && ir64) begin
        exp_q64.push_back(model(64, id64, int'(io64), isz64, isg64));
      end
      if (ov64 && or64) begin
        check("out64_expected_avail", 65'(exp_q64.size() != 0), 65'd1);
        if (exp_q64.size() != 0) begin
          e64 = exp_q64.pop_front();
          check("out64_result", {oe64, od64}, e64);
        end
      end
    end
  end

  // driver tasks: offer one request, return #1 after the accepting edge
  task automatic send32(input logic [31:0] d, input logic [1:0] off,
                        input logic [1:0] sz, input logic s);
    logic acc;
    int n;
    iv32 = 1'b1; id32 = d; io32 = off; isz32 = sz; isg32 = s;
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin
      @(negedge clk); acc = ir32;
      @(posedge clk); #1;
      n++;
    end
    iv32 = 1'b0;
    if (!acc) check("send32_accept_timeout", 65'(acc), 65'd1);
  endtask

  task automatic send64(input logic [63:0] d, input logic [2:0] off,
                        input logic [1:0] sz, input logic s);
    logic acc;
    int n;
    iv64 = 1'b1; id64 = d; io64 = off; isz64 = sz; isg64 = s;
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin
      @(negedge clk); acc = ir64;
      @(posedge clk); #1;
      n++;
    end
    iv64 = 1'b0;
    if (!acc) check("send64_accept_timeout", 65'(acc), 65'd1);
  endtask

  initial begin
    logic [32:0] hold;
    int a0, p0, t0;
    // reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst32_out_valid", 65'(ov32), 65'd0);
    check("rst32_in_ready", 65'(ir32), 65'd1);
    check("rst32_out_data", 65'(od32), 65'd0);
    check("rst32_out_err", 65'(oe32), 65'd0);
    check("rst64_out_valid", 65'(ov64), 65'd0);
    check("rst64_in_ready", 65'(ir64), 65'd1);
    check("rst64_out_data", 65'(od64), 65'd0);
    rst_n = 1'b1;
    or32 = 1'b1; or64 = 1'b1;

    // directed extraction cases, 32-bit
    send32(32'h12F4_5678, 2'd1, 2'b00, 1'b1);
    send32(32'h12F4_5678, 2'd1, 2'b00, 1'b0);
    send32(32'h1234_8001, 2'd2, 2'b01, 1'b1);
    send32(32'h1234_8001, 2'd2, 2'b01, 1'b0);
    send32(32'h1234_8001, 2'd1, 2'b01, 1'b1);
    send32(32'h8765_4321, 2'd0, 2'b10, 1'b1);
    send32(32'h8765_4321, 2'd0, 2'b10, 1'b0);
    send32(32'h8765_4321, 2'd2, 2'b10, 1'b0);
    send32(32'h8765_4321, 2'd0, 2'b11, 1'b1);
    send32(32'h0000_0080, 2'd3, 2'b00, 1'b1);
    for (int i = 0; i < 8; i++)
      send32($urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    repeat (2) @(posedge clk);
    #1;

    // back-pressure: three requests offered, two fit
    or32 = 1'b0;
    a0 = acc_cnt32;
    iv32 = 1'b1; id32 = 32'hA1B2_C3D4; io32 = 2'd0; isz32 = 2'b00; isg32 = 1'b1;
    @(posedge clk); #1;
    check("bp_latency_out_valid", 65'(ov32), 65'd1);
    check("bp_in_ready_after_one", 65'(ir32), 65'd1);
    id32 = 32'h0000_FF00; io32 = 2'd2; isz32 = 2'b01; isg32 = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_after_two", 65'(ir32), 65'd0);
    check("bp_dbg_state_two", 65'(dbg32), 65'd2);
    hold = {oe32, od32};
    id32 = 32'h5566_7788; io32 = 2'd3; isz32 = 2'b00; isg32 = 1'b0;
    @(posedge clk); #1;
    check("bp_accepted_two", 65'(acc_cnt32 - a0), 65'd2);
    check("bp_stable_1", 65'({oe32, od32}), 65'(hold));
    check("bp_out_valid_held", 65'(ov32), 65'd1);
    @(posedge clk); #1;
    check("bp_stable_2", 65'({oe32, od32}), 65'(hold));
    check("bp_still_full", 65'(ir32), 65'd0);
    or32 = 1'b1;
    @(posedge clk); #1;
    check("drain_1_valid", 65'(ov32), 65'd1);
    @(posedge clk); #1;
    iv32 = 1'b0;
    check("drain_2_valid", 65'(ov32), 65'd1);
    check("drain_third_accepted", 65'(acc_cnt32 - a0), 65'd3);
    @(posedge clk); #1;
    check("drain_empty", 65'(ov32), 65'd0);

    // streaming: 16 back-to-back with out_ready high
    p0 = pop_cnt32;
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      send32($urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      if (i == 0) check("stream_first_latency", 65'(ov32), 65'd1);
    end
    check("stream_accept_cycles", 65'(cyc - t0), 65'd16);
    check("stream_last_valid", 65'(ov32), 65'd1);
    @(posedge clk); #1;
    check("stream_results", 65'(pop_cnt32 - p0), 65'd16);
    check("stream_idle", 65'(ov32), 65'd0);

    // reset with two entries buffered
    or32 = 1'b0;
    send32(32'hDEAD_BEEF, 2'd0, 2'b00, 1'b1);
    send32(32'hCAFE_F00D, 2'd2, 2'b01, 1'b0);
    check("mid_dbg_state_two", 65'(dbg32), 65'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_out_valid", 65'(ov32), 65'd0);
    check("mid_rst_in_ready", 65'(ir32), 65'd1);
    check("mid_rst_out_data", 65'(od32), 65'd0);
    check("mid_rst_out_err", 65'(oe32), 65'd0);
    or32 = 1'b1;
    p0 = pop_cnt32;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_nothing_appears", 65'(pop_cnt32 - p0), 65'd0);
    send32(32'h0102_0304, 2'd3, 2'b00, 1'b0);

    // 64-bit width
    send64(64'h1122_3344_5566_8AF5, 3'd7, 2'b00, 1'b1);
    send64(64'h1122_3344_5566_8AF5, 3'd7, 2'b00, 1'b0);
    send64(64'h1122_3344_5566_8AF5, 3'd6, 2'b01, 1'b1);
    send64(64'h1122_3344_5566_8AF5, 3'd6, 2'b01, 1'b0);
    send64(64'h1122_3344_5566_8AF5, 3'd7, 2'b01, 1'b1);
    send64(64'h1122_3344_5566_8AF5, 3'd0, 2'b10, 1'b1);
    send64(64'h1122_3344_5566_8AF5, 3'd4, 2'b10, 1'b1);
    send64(64'h1122_3344_5566_8AF5, 3'd0, 2'b11, 1'b0);
    send64(64'hF011_2233_4455_6677, 3'd0, 2'b00, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("q32_drained", 65'(exp_q32.size()), 65'd0);
    check("q64_drained", 65'(exp_q64.size()), 65'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
